// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner encoding, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  // Width of the read-latency counter; bounds MEM_LAT to 1..15.
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch (IF) and data (DM) requesters; optional round-robin via ARB_ROUND_ROBIN_EN.
// Latency: combinational; the round-robin history flop updates on each grant edge.
// Backpressure: no grant while en_i is low; a loser simply keeps its request held.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic   clk,
  input  logic   reset_n,
`endif
  input  logic   en_i,
  input  logic   if_req_i,
  input  logic   dm_req_i,
  output logic   gnt_vld_o,
  output owner_e win_o
);

  logic dm_wins;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;

  // On a conflict, favour whoever was not granted most recently.
  always_comb begin
    dm_wins = dm_req_i && (!if_req_i || (last_q == OWN_IF));
    last_d  = gnt_vld_o ? win_o : last_q;
  end

  // Remember the last winner; starts as IF so DM takes the first conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= OWN_IF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: DM always beats IF.
  assign dm_wins = dm_req_i;
`endif

  assign gnt_vld_o = en_i && (if_req_i || dm_req_i);
  assign win_o     = dm_wins ? OWN_DM : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and DM; optional round-robin arbitration via ARB_ROUND_ROBIN_EN.
// Latency: gnt and mem_en in cycle T, rvalid pulse and registered rdata in cycle T+MEM_LAT+1.
// Backpressure: one access in flight; requesters hold req until gnt, new grants only in IDLE or RESP.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  if ((MEM_LAT < 1) || (MEM_LAT > (2**LAT_CNT_W) - 1)) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT);

  arb_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  owner_e               owner_q, owner_d;
  logic                 we_q, we_d;
  logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]    dm_rdata_q, dm_rdata_d;

  logic   can_grant;
  logic   gnt_vld;
  owner_e win;

  // Grants only when the port is free; reset_n gating keeps gnt/mem_en low while reset is held.
  assign can_grant = reset_n && ((state_q == IDLE) || (state_q == RESP));

  mem_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clk       (clk),
    .reset_n   (reset_n),
`endif
    .en_i      (can_grant),
    .if_req_i  (if_req),
    .dm_req_i  (dm_req),
    .gnt_vld_o (gnt_vld),
    .win_o     (win)
  );

  // Next state: latch owner on grant, count out the memory latency, capture read data on the last WAIT cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (gnt_vld) begin
          state_d = WAIT;
          cnt_d   = LAT_CNT_W'(1);
          owner_d = win;
          we_d    = (win == OWN_DM) && dm_we;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          if (owner_q == OWN_DM) begin
            // A store returns an all-zero word alongside its ack.
            dm_rdata_d = we_q ? '0 : mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, owner and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Grant-cycle outputs: the winner's request steers the memory port directly.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (gnt_vld) begin
      mem_en = 1'b1;
      if (win == OWN_DM) begin
        dm_gnt    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_be    = dm_be;
      end else begin
        if_gnt   = 1'b1;
        mem_addr = if_addr;
      end
    end
  end

  assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_rvalid = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (IF) and the data load/store requester (DM).
- Sits between the core datapath (PC/fetch and data-memory access stage) and the memory macro.
- Grants one access at a time, hides the fixed memory read latency with a counter-driven FSM, and returns data with a one-cycle valid pulse.
- Gives the core a stall source: the core holds a request until it is granted, then waits for rvalid.

Parameters:
ADDR_W, 32, address width for both requesters and the memory.
DATA_W, 32, data width.
MEM_LAT, 1, cycles from mem_en to a valid mem_rdata; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
if_req  in  1  fetch request; held until if_gnt.
if_addr  in  ADDR_W  fetch address.
if_gnt  out  1  fetch granted; combinational, one cycle.
if_rvalid  out  1  fetch data valid; one-cycle pulse.
if_rdata  out  DATA_W  fetch data; registered.
dm_req  in  1  data request; held until dm_gnt.
dm_we  in  1  1 = store, 0 = load.
dm_addr  in  ADDR_W  data address.
dm_wdata  in  DATA_W  store data.
dm_be  in  DATA_W/8  store byte enables.
dm_gnt  out  1  data granted; combinational, one cycle.
dm_rvalid  out  1  load data valid or store ack; one-cycle pulse.
dm_rdata  out  DATA_W  load data; registered, 0 for a store.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_be  out  DATA_W/8  memory byte enables.
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs go to 0; the FSM goes to IDLE; the latency counter goes to 0; the owner register clears.
  - Reset asserted mid-access abandons the access; no rvalid is produced for it.
- Each cycle has at most one gnt.
- A grant can be issued only in IDLE or RESP.
- Grant cycle T:
  - The gnt of the winner is high.
  - mem_en=1, and mem_addr/mem_we/mem_wdata/mem_be are driven combinationally from the winner.
  - For an IF grant, mem_we=0 and mem_be=0.
  - The owner is latched; the FSM goes to WAIT; the counter is loaded with 1.
- WAIT:
  - mem_en=0.
  - The counter increments each cycle.
  - When the counter equals MEM_LAT, mem_rdata is captured into the owner's rdata register at the clock edge, and the FSM goes to RESP.
- RESP:
  - The owner's rvalid is high for exactly one cycle, i.e. cycle T+MEM_LAT+1.
  - The rdata register holds its value until the next capture.
  - A new grant may be issued in this same cycle, so back-to-back throughput is one access per MEM_LAT+1 cycles.
  - With no request pending, the FSM goes to IDLE.
- Stores:
  - Follow the same timing.
  - dm_rvalid acts as the write-complete ack.
  - dm_rdata is 0.
- Arbitration with if_req and dm_req both high: DM wins (fixed priority).
- Requests deasserted before gnt are legal and simply ignored.
- A req sampled in WAIT is not granted until RESP.
- rvalid and gnt to the same requester in the same RESP cycle are legal; the core must accept both.
- Address and data are not modified; there is no alignment check.
- Counter width is 4 bits. MEM_LAT outside 1..15 is a static error.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requesters ask, the winner is the one not granted most recently.
  - A last-winner flip-flop resets to IF, so DM wins the first conflict.
- Undefined:
  - DM has fixed priority.
  - The last-winner flop is absent.

Decomposition:
- Shared package, e.g. the team's riscv core package, holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the owner encoding (OWN_IF=0, OWN_DM=1);
  - constant LAT_CNT_W=4.
- Natural sub-module: mem_arb_pick.
  - Combinational winner select with the priority / round-robin choice.
  - Keeps the ARB_ROUND_ROBIN_EN ifdef out of the FSM.

Test Plan:
1. Reset check: reset_n=0 with if_req=1 -> all outputs 0. Release reset -> if_gnt=1 next cycle in IDLE. With MEM_LAT=1, if_rvalid pulses 2 cycles after the grant, with if_rdata equal to memory word 0x00000013.
2. Conflict: if_req=dm_req=1 together, dm_we=0, dm_addr=0x100 holds 0xDEADBEEF -> dm_gnt first, dm_rvalid with 0xDEADBEEF. In the dm RESP cycle if_gnt=1 (back-to-back), and if_rvalid follows MEM_LAT+1 cycles later.
3. Store: dm_we=1, dm_addr=0x104, dm_wdata=0xCAFEF00D, dm_be=4'b0011 -> mem_we=1 and mem_be=0011 in the grant cycle. dm_rvalid pulses with dm_rdata=0. A later load of 0x104 returns 0x0000F00D when memory was zero beforehand.
4. Latency sweep: MEM_LAT=3, continuous if_req -> if_gnt every 4 cycles, if_rvalid exactly 4 cycles after each grant, mem_en never high in WAIT.
5. Mid-op reset: pull reset_n low in WAIT -> no rvalid afterwards. The FSM is in IDLE and the first request after release is granted normally.
6. ARB_ROUND_ROBIN_EN defined, both requests held continuously -> grants alternate DM, IF, DM, IF. With the macro undefined, the same stimulus -> DM only, and if_gnt stays 0.
